// File: rtl/f_case2_sched.sv
// Job scheduler for the F_case2 engine: latches H per job and feeds queued candidate
// vectors one at a time, keeping a single request in flight and holding each result.
module f_case2_sched #(
    parameter int J       = 14,
    parameter int A       = 2,
    parameter int AWIDTH  = $clog2(A) + 1,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [J*64-1:0]       h_in,
    input  logic                  h_in_valid,
    output logic                  h_in_ready,
    input  logic [J*AWIDTH-1:0]   x_in,
    input  logic                  x_in_last,
    input  logic                  x_in_valid,
    output logic                  x_in_ready,
    output logic [J*64-1:0]       eng_H,
    output logic                  eng_H_tvalid,
    output logic [J*AWIDTH-1:0]   eng_x,
    output logic                  eng_x_tvalid,
    input  logic [J*AWIDTH-1:0]   eng_F_value,
    input  logic                  eng_F_tvalid,
    output logic [J*AWIDTH-1:0]   res_data,
    output logic [7:0]            res_idx,
    output logic                  res_last,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  err_timeout,
    output logic                  busy
);

    // state   | meaning
    // IDLE    | waiting for a job (h_in handshake)
    // FETCH   | pop next candidate when the FIFO has one
    // ISSUE   | one-cycle tvalid pulse towards the engine
    // WAIT    | engine request in flight, timer running
    // OUT     | result held until res_ready
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    localparam int XW = J * AWIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;
    localparam logic [15:0] TMO = TIMEOUT[15:0];

    logic [2:0]    state;
    logic [XW:0]   mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          last_q;
    logic [7:0]    idx;
    logic [15:0]   timer;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push  = x_in_valid && !full;
    assign pop   = (state == S_FETCH) && !empty;

    assign x_in_ready = !full;
    assign h_in_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= {x_in_last, x_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            eng_H        <= '0;
            eng_x        <= '0;
            eng_H_tvalid <= 1'b0;
            eng_x_tvalid <= 1'b0;
            last_q       <= 1'b0;
            idx          <= '0;
            timer        <= '0;
            res_data     <= '0;
            res_idx      <= '0;
            res_last     <= 1'b0;
            res_valid    <= 1'b0;
            err_timeout  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            err_timeout  <= 1'b0;
            eng_H_tvalid <= 1'b0;
            eng_x_tvalid <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case (state)
                S_IDLE: begin
                    if (h_in_valid) begin
                        eng_H <= h_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (pop) begin
                        eng_x  <= mem[rd_ptr[PW-1:0]][XW-1:0];
                        last_q <= mem[rd_ptr[PW-1:0]][XW];
                        rd_ptr <= rd_ptr + PTR_ONE;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    eng_H_tvalid <= 1'b1;
                    eng_x_tvalid <= 1'b1;
                    timer        <= '0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (eng_F_tvalid) begin
                        res_data  <= eng_F_value;
                        res_idx   <= idx;
                        res_last  <= last_q;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (timer == TMO) begin
                        err_timeout <= 1'b1;
                        idx         <= idx + 8'd1;
                        if (last_q) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        idx       <= idx + 8'd1;
                        if (res_last) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
